// File: rtl/neurosync_pkg.sv
// rtl/neurosync_pkg.sv - shared types and LED/button index helpers for the neurosync player
package neurosync_pkg;

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    OUVINDO   = 3'd1,
    PRESSIONA = 3'd2,
    SOLTA     = 3'd3
  } estado_autojogador_t;

  function automatic logic eh_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] onehot_para_indice(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    case (v)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic [3:0] indice_para_onehot(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

endpackage

// File: rtl/neurosync_fila_jogadas.sv
// rtl/neurosync_fila_jogadas.sv - PROF x 2-bit play buffer with count, flags and synchronous clear
module neurosync_fila_jogadas
  import neurosync_pkg::*;
#(
  parameter int PROF = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   limpar,
  input  logic                   escrever,
  input  logic [1:0]             dado_esc,
  input  logic                   avancar,
  output logic [1:0]             dado_atual,
  output logic [1:0]             dado_prox,
  output logic [$clog2(PROF):0]  num_itens,
  output logic                   cheia,
  output logic                   vazia
);

  localparam int AW = $clog2(PROF);
  localparam int NW = AW + 1;

  logic [1:0]    mem [PROF];
  logic [AW-1:0] wr;
  logic [AW-1:0] rd;
  logic [AW-1:0] rd_prox;
  logic          grava;
  logic          le;

  assign cheia      = (num_itens == NW'(PROF));
  assign vazia      = (num_itens == '0);
  assign grava      = escrever && !cheia && !limpar;
  assign le         = avancar && !vazia && !limpar;
  assign rd_prox    = rd + AW'(1);
  assign dado_atual = mem[rd];
  assign dado_prox  = mem[rd_prox];

  always_ff @(posedge clock) begin
    if (grava) mem[wr] <= dado_esc;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr        <= '0;
      rd        <= '0;
      num_itens <= '0;
    end else if (limpar) begin
      wr        <= '0;
      rd        <= '0;
      num_itens <= '0;
    end else begin
      if (grava) wr <= wr + AW'(1);
      if (le)    rd <= rd_prox;
      num_itens <= num_itens + NW'(grava) - NW'(le);
    end
  end

endmodule

// File: rtl/neurosync_autojogador.sv
// rtl/neurosync_autojogador.sv - records neurosync LED flashes and replays them as button presses
// Optional NEUROSYNC_AUTOJOGADOR_FALHA_EN adds forca_falha to corrupt the last replayed item.
module neurosync_autojogador
  import neurosync_pkg::*;
#(
  parameter int PROF       = 16,
  parameter int T_SILENCIO = 200,
  parameter int T_PRESS    = 10,
  parameter int T_GAP      = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   habilitar,
  input  logic [3:0]             leds,
  input  logic                   pronto,
`ifdef NEUROSYNC_AUTOJOGADOR_FALHA_EN
  input  logic                   forca_falha,
`endif
  output logic [3:0]             botoes,
  output logic                   ocupado,
  output logic                   erro,
  output logic [$clog2(PROF):0]  db_num_itens,
  output logic [2:0]             db_estado
);

  localparam int NW = $clog2(PROF) + 1;
  localparam int SW = $clog2(T_SILENCIO + 1);
  localparam int TW = $clog2((T_PRESS > T_GAP ? T_PRESS : T_GAP) + 1);
  localparam logic [SW-1:0] SIL_MAX   = SW'(T_SILENCIO - 1);
  localparam logic [TW-1:0] PRESS_MAX = TW'(T_PRESS - 1);
  localparam logic [TW-1:0] GAP_MAX   = TW'(T_GAP - 1);

  estado_autojogador_t estado;
  logic [3:0]    leds_q;
  logic [SW-1:0] cnt_sil;
  logic [TW-1:0] cnt_tempo;

  logic [1:0]    dado_atual, dado_prox, idx_envio;
  logic [NW-1:0] num_itens;
  logic          cheia, vazia;
  logic          borda, fim_solta, ultimo, expira, envia_ultimo;
  logic          escrever, avancar, limpar;

  always_comb begin
    borda        = (leds != 4'd0) && (leds_q == 4'd0);
    fim_solta    = (estado == SOLTA) && (cnt_tempo == GAP_MAX);
    ultimo       = (num_itens == NW'(1));
    expira       = (leds == 4'd0) && (cnt_sil == SIL_MAX);
    escrever     = habilitar && !pronto && (estado == OUVINDO) && borda && eh_onehot(leds);
    avancar      = habilitar && !pronto && fim_solta;
    limpar       = !habilitar || pronto || (fim_solta && ultimo);
    // From SOLTA the pointer has not advanced yet, so the next item sits one slot ahead.
    idx_envio    = (estado == SOLTA) ? dado_prox : dado_atual;
    envia_ultimo = (estado == SOLTA) ? (num_itens == NW'(2)) : ultimo;
`ifdef NEUROSYNC_AUTOJOGADOR_FALHA_EN
    if (forca_falha && envia_ultimo) idx_envio = idx_envio + 2'd1;
`else
    if (envia_ultimo) idx_envio = idx_envio;
`endif
  end

  neurosync_fila_jogadas #(.PROF(PROF)) u_fila (
    .clock      (clock),
    .reset      (reset),
    .limpar     (limpar),
    .escrever   (escrever),
    .dado_esc   (onehot_para_indice(leds)),
    .avancar    (avancar),
    .dado_atual (dado_atual),
    .dado_prox  (dado_prox),
    .num_itens  (num_itens),
    .cheia      (cheia),
    .vazia      (vazia)
  );

  assign db_num_itens = num_itens;
  assign db_estado    = estado;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado    <= OCIOSO;
      leds_q    <= 4'd0;
      cnt_sil   <= '0;
      cnt_tempo <= '0;
      botoes    <= 4'd0;
      ocupado   <= 1'b0;
      erro      <= 1'b0;
    end else begin
      leds_q <= leds;
      if (leds != 4'd0)        cnt_sil <= '0;
      else if (cnt_sil != SIL_MAX) cnt_sil <= cnt_sil + SW'(1);

      if (!habilitar) begin
        estado    <= OCIOSO;
        botoes    <= 4'd0;
        ocupado   <= 1'b0;
        erro      <= 1'b0;
        cnt_tempo <= '0;
      end else if (pronto) begin
        estado    <= OUVINDO;
        botoes    <= 4'd0;
        ocupado   <= 1'b0;
        cnt_tempo <= '0;
      end else begin
        case (estado)
          OCIOSO: estado <= OUVINDO;
          OUVINDO: begin
            if (borda && (!eh_onehot(leds) || cheia)) erro <= 1'b1;
            if (expira && !vazia) begin
              estado    <= PRESSIONA;
              botoes    <= indice_para_onehot(idx_envio);
              ocupado   <= 1'b1;
              cnt_tempo <= '0;
            end
          end
          PRESSIONA: begin
            if (cnt_tempo == PRESS_MAX) begin
              estado    <= SOLTA;
              botoes    <= 4'd0;
              cnt_tempo <= '0;
            end else begin
              cnt_tempo <= cnt_tempo + TW'(1);
            end
          end
          SOLTA: begin
            if (fim_solta && ultimo) begin
              estado  <= OUVINDO;
              ocupado <= 1'b0;
            end else if (fim_solta) begin
              estado    <= PRESSIONA;
              botoes    <= indice_para_onehot(idx_envio);
              cnt_tempo <= '0;
            end else begin
              cnt_tempo <= cnt_tempo + TW'(1);
            end
          end
          default: estado <= OCIOSO;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_neurosync_autojogador.sv
// tb/tb_neurosync_autojogador.sv - directed bench with a replay-schedule model for neurosync_autojogador
module tb_neurosync_autojogador;

  localparam int PROF = 16, T_SILENCIO = 200, T_PRESS = 10, T_GAP = 10;
  localparam int L = T_PRESS + T_GAP;

  logic       clock = 1'b0;
  logic       reset, habilitar, pronto;
  logic [3:0] leds;
  logic       forca_falha, falha_in;
  logic [3:0] botoes;
  logic       ocupado, erro;
  logic [4:0] db_num_itens;
  logic [2:0] db_estado;

  int tests = 0, fails = 0;
  bit checking = 0;

  always #5 clock = ~clock;

  neurosync_autojogador #(.PROF(PROF), .T_SILENCIO(T_SILENCIO), .T_PRESS(T_PRESS), .T_GAP(T_GAP)) dut (
    .clock        (clock),
    .reset        (reset),
    .habilitar    (habilitar),
    .leds         (leds),
    .pronto       (pronto),
`ifdef NEUROSYNC_AUTOJOGADOR_FALHA_EN
    .forca_falha  (forca_falha),
`endif
    .botoes       (botoes),
    .ocupado      (ocupado),
    .erro         (erro),
    .db_num_itens (db_num_itens),
    .db_estado    (db_estado)
  );

`ifdef NEUROSYNC_AUTOJOGADOR_FALHA_EN
  assign falha_in = forca_falha;
`else
  assign falha_in = 1'b0;
`endif

  // Model: 0 idle, 1 listening, 2 replaying; replay outputs follow from elapsed time.
  int fila[$], rep[$];
  int m_state, m_dark, m_t;
  logic [3:0] m_prev;
  bit m_erro, m_rot, m_borda;

  function automatic int indice(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_state = 0; fila.delete(); rep.delete();
      m_prev = 0; m_dark = 0; m_erro = 0; m_t = 0; m_rot = 0;
    end else begin
      m_borda = (leds != 0) && (m_prev == 0);
      m_prev  = leds;
      m_dark  = (leds != 0) ? 0 : m_dark + 1;
      if (!habilitar) begin
        m_state = 0; fila.delete(); m_erro = 0;
      end else if (pronto) begin
        m_state = 1; fila.delete();
      end else if (m_state == 0) begin
        m_state = 1;
      end else if (m_state == 1) begin
        if (m_borda) begin
          if ($countones(leds) == 1 && fila.size() < PROF) fila.push_back(indice(leds));
          else m_erro = 1;
        end else if (m_dark >= T_SILENCIO && fila.size() > 0) begin
          rep = fila; m_t = 0; m_state = 2;
          m_rot = falha_in && (rep.size() == 1);
        end
      end else begin
        m_t++;
        if (m_t == rep.size() * L) begin
          m_state = 1; fila.delete();
        end else if (m_t == (rep.size() - 1) * L) begin
          m_rot = falha_in;
        end
      end
    end
  end

  always @(negedge clock) begin
    int j, ph, e_est, e_oc, e_num;
    logic [3:0] e_b;
    if (checking) begin
      if (m_state == 2) begin
        j = m_t / L; ph = m_t % L;
        e_est = (ph < T_PRESS) ? 2 : 3;
        e_b = (ph < T_PRESS) ? 4'(1 << ((rep[j] + ((m_rot && j == rep.size() - 1) ? 1 : 0)) % 4)) : 4'd0;
        e_oc = 1; e_num = rep.size() - j;
      end else begin
        e_est = m_state; e_b = 0; e_oc = 0; e_num = fila.size();
      end
      tests++;
      if (botoes !== e_b || ocupado !== e_oc[0] || erro !== m_erro || db_num_itens !== e_num[4:0] || db_estado !== e_est[2:0]) begin
        fails++;
        $display("FAIL model t=%0t: botoes=%b ocupado=%b erro=%b num=%0d estado=%0d, expected %b %b %b %0d %0d",
                 $time, botoes, ocupado, erro, db_num_itens, db_estado, e_b, e_oc[0], m_erro, e_num, e_est);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clock); #2; end
  endtask

  task automatic check(input string nome, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nome, act, exp);
    end
  endtask

  task automatic flash(input logic [3:0] v, input int on, input int off);
    leds = v; cyc(on); leds = 0; cyc(off);
  endtask

  task automatic espera(input bit nz, input int budget, input string nome);
    int k;
    for (k = 0; k < budget; k++) begin
      if ((botoes != 0) == nz) break;
      cyc(1);
    end
    tests++;
    if (k == budget) begin
      fails++;
      $display("FAIL %s: timeout after %0d cycles, expected botoes nonzero=%0d", nome, budget, nz);
    end
  endtask

  int n_ocup;
  logic [3:0] seq[$];

  task automatic observa(input int ciclos);
    logic [3:0] ant;
    ant = botoes; n_ocup = 0; seq.delete();
    for (int i = 0; i < ciclos; i++) begin
      cyc(1);
      if (ocupado) n_ocup++;
      if (botoes != 0 && ant == 0) seq.push_back(botoes);
      ant = botoes;
    end
  endtask

  initial begin
    reset = 0; habilitar = 0; leds = 0; pronto = 0; forca_falha = 0;
    cyc(1);
    checking = 1;
    check("reset_botoes", botoes, 0);
    check("reset_estado", db_estado, 0);
    check("reset_num", db_num_itens, 0);
    reset = 1;

    // single item: exact press timing
    habilitar = 1; cyc(2);
    flash(4'b0001, 5, 0);
    cyc(1);   check("a_num_after_capture", db_num_itens, 1);
    cyc(198); check("a_no_press_d199", botoes, 0);
    cyc(1);   check("a_press_d200", botoes, 4'b0001);
              check("a_estado_press", db_estado, 2);
    cyc(9);   check("a_press_d209", botoes, 4'b0001);
    cyc(1);   check("a_release_d210", botoes, 0);
              check("a_estado_solta", db_estado, 3);
    cyc(9);   check("a_ocupado_d219", ocupado, 1);
    cyc(1);   check("a_estado_end", db_estado, 1);
              check("a_num_end", db_num_itens, 0);
              check("a_ocupado_end", ocupado, 0);

    // three items
    flash(4'b0100, 2, 3); flash(4'b0010, 2, 3); flash(4'b1000, 2, 0);
    observa(300);
    check("b_ocupado_cycles", n_ocup, 60);
    check("b_presses", seq.size(), 3);
    if (seq.size() == 3) begin
      check("b_seq0", seq[0], 4'b0100);
      check("b_seq1", seq[1], 4'b0010);
      check("b_seq2", seq[2], 4'b1000);
    end

    // invalid pattern, then overflow
    flash(4'b0110, 2, 3);
    check("c_erro_invalid", erro, 1);
    check("c_num_invalid", db_num_itens, 0);
    observa(250);
    check("c_no_replay_empty", n_ocup, 0);
    habilitar = 0; cyc(1); habilitar = 1; cyc(1);
    check("c_erro_cleared", erro, 0);
    for (int i = 0; i < 16; i++) flash(4'(1 << (i % 4)), 1, 1);
    check("c_num_full", db_num_itens, 16);
    check("c_erro_full", erro, 0);
    flash(4'b0001, 1, 1);
    check("c_erro_overflow", erro, 1);
    check("c_num_overflow", db_num_itens, 16);
    observa(560);
    check("c_presses", seq.size(), 16);
    check("c_ocupado_cycles", n_ocup, 16 * L);
    if (seq.size() == 16) check("c_seq13", seq[13], 4'b0010);

    // pronto during second press
    flash(4'b0001, 2, 3); flash(4'b0010, 2, 3); flash(4'b0100, 2, 0);
    espera(1, 400, "d_first_press");
    espera(0, 30, "d_first_release");
    espera(1, 30, "d_second_press");
    cyc(3); check("d_second_value", botoes, 4'b0010);
    pronto = 1; cyc(1);
    check("d_pronto_botoes", botoes, 0);
    check("d_pronto_num", db_num_itens, 0);
    check("d_pronto_estado", db_estado, 1);
    pronto = 0;
    observa(300);
    check("d_no_replay_after_pronto", n_ocup, 0);

    // forced fault on the last item (exact replay when the option is absent)
    forca_falha = 1;
    flash(4'b0001, 2, 3); flash(4'b1000, 2, 0);
    observa(300);
    check("e_presses", seq.size(), 2);
    if (seq.size() == 2) begin
      check("e_seq0", seq[0], 4'b0001);
`ifdef NEUROSYNC_AUTOJOGADOR_FALHA_EN
      check("e_seq1", seq[1], 4'b0001);
`else
      check("e_seq1", seq[1], 4'b1000);
`endif
    end
    forca_falha = 0;

    // asynchronous reset mid-press
    flash(4'b0010, 2, 0);
    espera(1, 400, "f_press");
    cyc(2);
    reset = 0; #1;
    check("f_async_botoes", botoes, 0);
    check("f_async_estado", db_estado, 0);
    check("f_async_ocupado", ocupado, 0);
    cyc(1); reset = 1; cyc(3);

    checking = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
